memory_arbiter: RTL and testbench



---
 rtl/memory_arbiter_pkg.sv | 21 ++
 rtl/arb_watchdog.sv | 40 ++++
 rtl/memory_arbiter.sv | 140 ++++++++++++++
 tb/tb_memory_arbiter.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/memory_arbiter_pkg.sv
// Shared types for the instruction/data memory arbiter: FSM states,
// transaction owner encoding and watchdog sizing.
package memory_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_GRANT = 2'd1,
    ARB_RESP  = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWNER_INSTR = 1'b0,
    OWNER_DATA  = 1'b1
  } owner_e;

  // Counter width able to hold TIMEOUT_CYCLES, never narrower than one bit.
  function automatic int unsigned wd_width(input int unsigned timeout);
    return (timeout < 2) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/arb_watchdog.sv
// Loadable up-counter with clear/enable that flags when the next enabled
// cycle would reach TIMEOUT_CYCLES; never expires when TIMEOUT_CYCLES is 0.
module arb_watchdog
  import memory_arbiter_pkg::*;
#(
  parameter  int unsigned TIMEOUT_CYCLES = 255,
  localparam int unsigned CW             = wd_width(TIMEOUT_CYCLES)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_clear,
  input  logic          i_en,
  input  logic          i_load,
  input  logic [CW-1:0] i_load_val,
  output logic          o_expired
);

  logic [CW-1:0] r_count;

  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en) begin
      r_count <= r_count + 1'b1;
    end
  end

  // Expiry is flagged in the last enabled cycle so the owner's FSM leaves
  // GRANT on the same edge the count reaches TIMEOUT_CYCLES.
  generate
    if (TIMEOUT_CYCLES == 0) begin : g_disabled
      assign o_expired = 1'b0;
    end else begin : g_enabled
      assign o_expired = i_en && (r_count == CW'(TIMEOUT_CYCLES - 1));
    end
  endgenerate

endmodule

// File: rtl/memory_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch and
// load/store, with registered transactions and a timeout watchdog.
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_req,
  input  logic [ADDR_WIDTH-1:0]   i_addr,
  output logic [DATA_WIDTH-1:0]   i_rdata,
  output logic                    i_ack,
  output logic                    i_err,
  input  logic                    d_req,
  input  logic                    d_we,
  input  logic [ADDR_WIDTH-1:0]   d_addr,
  input  logic [DATA_WIDTH-1:0]   d_wdata,
  input  logic [DATA_WIDTH/8-1:0] d_wstrb,
  output logic [DATA_WIDTH-1:0]   d_rdata,
  output logic                    d_ack,
  output logic                    d_err,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_wstrb,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  input  logic                    mem_ack
);

  arb_state_e r_state, w_next_state;
  owner_e     r_owner, r_last_grant, w_grant_owner;
  logic       w_grant_valid, w_enter_grant, w_done, w_wd_en, w_wd_expired;
  logic [DATA_WIDTH-1:0] w_resp_data;

  always_comb begin
    w_grant_valid = i_req | d_req;
    w_grant_owner = OWNER_INSTR;
    if (i_req && d_req) begin
      w_grant_owner = (r_last_grant == OWNER_INSTR) ? OWNER_DATA : OWNER_INSTR;
    end else if (d_req) begin
      w_grant_owner = OWNER_DATA;
    end
  end

  assign w_wd_en       = (r_state == ARB_GRANT);
  assign w_enter_grant = (r_state == ARB_IDLE) && w_grant_valid;
  // mem_ack takes priority over a simultaneous expiry.
  assign w_done        = w_wd_en && (mem_ack || w_wd_expired);
  assign w_resp_data   = (mem_ack && !mem_we) ? mem_rdata : '0;

  arb_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk        (clk),
    .reset      (reset),
    .i_clear    (w_enter_grant),
    .i_en       (w_wd_en),
    .i_load     (1'b0),
    .i_load_val ('0),
    .o_expired  (w_wd_expired)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= ARB_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ARB_IDLE:  if (w_grant_valid) w_next_state = ARB_GRANT;
      ARB_GRANT: if (w_done)        w_next_state = ARB_RESP;
      ARB_RESP:                     w_next_state = ARB_IDLE;
      default:                      w_next_state = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_owner      <= OWNER_INSTR;
      r_last_grant <= OWNER_INSTR;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      mem_wstrb    <= '0;
      i_ack        <= 1'b0;
      i_err        <= 1'b0;
      i_rdata      <= '0;
      d_ack        <= 1'b0;
      d_err        <= 1'b0;
      d_rdata      <= '0;
    end else begin
      i_ack <= 1'b0;
      i_err <= 1'b0;
      d_ack <= 1'b0;
      d_err <= 1'b0;
      case (r_state)
        ARB_IDLE: begin
          if (w_grant_valid) begin
            r_owner <= w_grant_owner;
            mem_req <= 1'b1;
            if (w_grant_owner == OWNER_DATA) begin
              mem_addr  <= d_addr;
              mem_we    <= d_we;
              mem_wdata <= d_wdata;
              mem_wstrb <= d_we ? d_wstrb : '0;
            end else begin
              mem_addr  <= i_addr;
              mem_we    <= 1'b0;
              mem_wdata <= '0;
              mem_wstrb <= '0;
            end
          end
        end
        ARB_GRANT: begin
          if (w_done) begin
            mem_req <= 1'b0;
            if (r_owner == OWNER_DATA) begin
              d_rdata <= w_resp_data;
              d_ack   <= 1'b1;
              d_err   <= !mem_ack;
            end else begin
              i_rdata <= w_resp_data;
              i_ack   <= 1'b1;
              i_err   <= !mem_ack;
            end
          end
        end
        ARB_RESP: r_last_grant <= r_owner;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed self-checking bench for memory_arbiter (TIMEOUT_CYCLES=4); memory
// responses are driven by hand at fixed cycles.
module tb_memory_arbiter;

  logic        clk;
  logic        reset;
  logic        i_req;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_ack;
  logic        i_err;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_wstrb;
  logic [31:0] d_rdata;
  logic        d_ack;
  logic        d_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  memory_arbiter #(
    .ADDR_WIDTH    (32),
    .DATA_WIDTH    (32),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .i_req    (i_req),
    .i_addr   (i_addr),
    .i_rdata  (i_rdata),
    .i_ack    (i_ack),
    .i_err    (i_err),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_wstrb  (d_wstrb),
    .d_rdata  (d_rdata),
    .d_ack    (d_ack),
    .d_err    (d_err),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb),
    .mem_rdata(mem_rdata),
    .mem_ack  (mem_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  logic [31:0] exp_addr [4];
  logic        exp_data [4];

  initial begin
    reset = 1'b1; i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_wstrb = '0;
    mem_rdata = '0; mem_ack = 1'b0;
    tick(); tick();

    // Reset values
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_we_wstrb", {27'd0, mem_we, mem_wstrb}, 32'd0);
    chk("rst_acks_errs", {28'd0, i_ack, i_err, d_ack, d_err}, 32'd0);
    chk("rst_rdata", i_rdata | d_rdata, 32'd0);
    reset = 1'b0;

    // Single fetch, zero-wait memory
    i_req = 1'b1; i_addr = 32'h0000_0010;
    tick();
    chk("f_mem_req", {31'd0, mem_req}, 32'd1);
    chk("f_mem_addr", mem_addr, 32'h0000_0010);
    chk("f_mem_we_wstrb", {27'd0, mem_we, mem_wstrb}, 32'd0);
    chk("f_no_ack_yet", {31'd0, i_ack}, 32'd0);
    mem_ack = 1'b1; mem_rdata = 32'h0000_0013;
    tick();
    mem_ack = 1'b0; i_req = 1'b0;
    chk("f_i_ack", {31'd0, i_ack}, 32'd1);
    chk("f_i_rdata", i_rdata, 32'h0000_0013);
    chk("f_i_err", {31'd0, i_err}, 32'd0);
    chk("f_d_ack", {31'd0, d_ack}, 32'd0);
    chk("f_mem_req_low", {31'd0, mem_req}, 32'd0);
    tick();
    chk("f_ack_one_cycle", {31'd0, i_ack}, 32'd0);

    // Data write with two wait states
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF; d_wstrb = 4'hF;
    mem_rdata = 32'h5555_5555;
    tick();
    for (int k = 0; k < 3; k++) begin
      chk("w_mem_req", {31'd0, mem_req}, 32'd1);
      chk("w_mem_fields", {mem_addr[27:0], mem_we, 3'd0}, {28'h100, 1'b1, 3'd0});
      chk("w_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
      chk("w_mem_wstrb", {28'd0, mem_wstrb}, 32'hF);
      chk("w_no_ack", {30'd0, d_ack, i_ack}, 32'd0);
      if (k == 2) mem_ack = 1'b1;
      tick();
    end
    mem_ack = 1'b0; d_req = 1'b0;
    chk("w_d_ack", {31'd0, d_ack}, 32'd1);
    chk("w_d_rdata_zero", d_rdata, 32'd0);
    chk("w_d_err", {31'd0, d_err}, 32'd0);
    chk("w_i_ack", {31'd0, i_ack}, 32'd0);
    tick();

    // Simultaneous requests from reset, both held
    reset = 1'b1;
    tick();
    reset = 1'b0;
    i_req = 1'b1; i_addr = 32'h200;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300; d_wstrb = 4'h0;
    exp_addr[0] = 32'h300; exp_data[0] = 1'b1;
    exp_addr[1] = 32'h200; exp_data[1] = 1'b0;
    exp_addr[2] = 32'h300; exp_data[2] = 1'b1;
    exp_addr[3] = 32'h200; exp_data[3] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("rr_grant_addr", mem_addr, exp_addr[k]);
      mem_ack = 1'b1; mem_rdata = 32'hA0 + 32'(k);
      tick();
      mem_ack = 1'b0;
      chk("rr_owner_ack", {31'd0, exp_data[k] ? d_ack : i_ack}, 32'd1);
      chk("rr_other_ack", {31'd0, exp_data[k] ? i_ack : d_ack}, 32'd0);
      chk("rr_owner_rdata", exp_data[k] ? d_rdata : i_rdata, 32'hA0 + 32'(k));
      tick();
    end
    i_req = 1'b0; d_req = 1'b0;

    // Watchdog timeout, memory never answers
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h400; mem_rdata = 32'hFFFF_FFFF;
    tick();
    for (int k = 0; k < 4; k++) begin
      chk("to_mem_req_high", {31'd0, mem_req}, 32'd1);
      chk("to_no_ack", {31'd0, d_ack}, 32'd0);
      tick();
    end
    d_req = 1'b0;
    chk("to_d_ack", {31'd0, d_ack}, 32'd1);
    chk("to_d_err", {31'd0, d_err}, 32'd1);
    chk("to_d_rdata", d_rdata, 32'd0);
    chk("to_mem_req_low", {31'd0, mem_req}, 32'd0);
    chk("to_i_flags", {30'd0, i_ack, i_err}, 32'd0);
    tick();
    tick();
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("late_ack_ignored", {28'd0, i_ack, i_err, d_ack, d_err}, 32'd0);
    chk("late_ack_mem_req", {31'd0, mem_req}, 32'd0);
    tick();
    chk("late_ack_still_quiet", {30'd0, i_ack, d_ack}, 32'd0);

    // Reset during the second wait cycle of a grant
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h500; d_wdata = 32'h1234_5678; d_wstrb = 4'hF;
    tick();
    tick();
    chk("rg_mem_req_pre", {31'd0, mem_req}, 32'd1);
    reset = 1'b1; i_req = 1'b1; i_addr = 32'h600;
    tick();
    reset = 1'b0;
    chk("rg_mem_req_drop", {31'd0, mem_req}, 32'd0);
    chk("rg_no_ack", {30'd0, i_ack, d_ack}, 32'd0);
    tick();
    chk("rg_data_first", mem_addr, 32'h500);
    chk("rg_data_we", {31'd0, mem_we}, 32'd1);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0; d_req = 1'b0;
    chk("rg_d_ack", {30'd0, d_ack, i_ack}, 32'd2);
    tick();
    tick();
    chk("rg_instr_next", mem_addr, 32'h600);
    mem_ack = 1'b1; mem_rdata = 32'h0BAD_F00D;
    tick();
    mem_ack = 1'b0; i_req = 1'b0;
    chk("rg_i_ack", {30'd0, i_ack, d_ack}, 32'd2);
    chk("rg_i_rdata", i_rdata, 32'h0BAD_F00D);
    tick();

    // Byte-lane write then an instruction fetch
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h700; d_wdata = 32'h0000_CAFE; d_wstrb = 4'h3;
    tick();
    chk("bl_mem_wstrb", {28'd0, mem_wstrb}, 32'h3);
    chk("bl_mem_we", {31'd0, mem_we}, 32'd1);
    chk("bl_mem_wdata", mem_wdata, 32'h0000_CAFE);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0; d_req = 1'b0;
    chk("bl_d_ack", {31'd0, d_ack}, 32'd1);
    i_req = 1'b1; i_addr = 32'h800;
    tick();
    tick();
    chk("bl_fetch_addr", mem_addr, 32'h800);
    chk("bl_fetch_we_wstrb", {27'd0, mem_we, mem_wstrb}, 32'd0);
    mem_ack = 1'b1; mem_rdata = 32'h0000_0077;
    tick();
    mem_ack = 1'b0; i_req = 1'b0;
    chk("bl_i_ack", {31'd0, i_ack}, 32'd1);
    chk("bl_i_rdata", i_rdata, 32'h0000_0077);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
